// File: rtl/frame_sequencer_if.sv
// FIFO-side handshake bundle for the frame sequencer: source read, datapath
// input write, datapath output read and sink write.
interface frame_sequencer_if #(
    parameter int DIN_W  = 24,
    parameter int DOUT_W = 8
) ();
    logic              src_empty;
    logic              src_rd_en;
    logic [DIN_W-1:0]  src_dout;
    logic              fifo_in_wr_en;
    logic [DIN_W-1:0]  fifo_in_din;
    logic              fifo_in_full;
    logic              fifo_out_empty;
    logic              fifo_out_rd_en;
    logic [DOUT_W-1:0] fifo_out_dout;
    logic              snk_wr_en;
    logic [DOUT_W-1:0] snk_din;
    logic              snk_full;

    modport master (
        input  src_empty, src_dout, fifo_in_full, fifo_out_empty, fifo_out_dout, snk_full,
        output src_rd_en, fifo_in_wr_en, fifo_in_din, fifo_out_rd_en, snk_wr_en, snk_din
    );

    modport slave (
        output src_empty, src_dout, fifo_in_full, fifo_out_empty, fifo_out_dout, snk_full,
        input  src_rd_en, fifo_in_wr_en, fifo_in_din, fifo_out_rd_en, snk_wr_en, snk_din
    );
endinterface

// File: rtl/frame_sequencer.sv
// Moves one frame of pixels source -> datapath and datapath -> sink, counting
// both sides, with a no-progress watchdog that ends the frame early.
module frame_sequencer #(
    parameter int FIFO_DWIDTH_IN  = 24,
    parameter int FIFO_DWIDTH_OUT = 8,
    parameter int CNT_WIDTH       = 20,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_frame_pixels,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_in_count,
    output logic [CNT_WIDTH-1:0] o_out_count,
    frame_sequencer_if.master    bus
);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [CNT_WIDTH-1:0] r_total, r_in_count, r_out_count;
    logic [WD_W-1:0]      r_wd;
    logic                 r_timeout;

    logic                       w_in_xfer, w_out_xfer, w_active, w_wd_fire;
    logic                       w_in_last, w_out_last, w_set_timeout, w_accept;
    logic [CNT_WIDTH-1:0]       w_in_next, w_out_next;
    logic [FIFO_DWIDTH_IN-1:0]  w_src_pix;
    logic [FIFO_DWIDTH_OUT-1:0] w_dp_pix;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_in_xfer  = (r_state == S_RUN) && (r_in_count != r_total) &&
                        !bus.src_empty && !bus.fifo_in_full;
    assign w_out_xfer = w_active && (r_out_count != r_total) &&
                        !bus.fifo_out_empty && !bus.snk_full;

    // "Reached total" must include the transfer happening this cycle.
    assign w_in_next  = r_in_count + CNT_WIDTH'(w_in_xfer);
    assign w_out_next = r_out_count + CNT_WIDTH'(w_out_xfer);
    assign w_in_last  = (w_in_next == r_total);
    assign w_out_last = (w_out_next == r_total);
    assign w_wd_fire  = w_active && !w_in_xfer && !w_out_xfer && (r_wd == WD_MAX);

    assign w_src_pix         = bus.src_dout;
    assign w_dp_pix          = bus.fifo_out_dout;
    assign bus.src_rd_en     = w_in_xfer;
    assign bus.fifo_in_wr_en = w_in_xfer;
    assign bus.fifo_in_din   = w_src_pix;
    assign bus.fifo_out_rd_en = w_out_xfer;
    assign bus.snk_wr_en     = w_out_xfer;
    assign bus.snk_din       = w_dp_pix;

    assign o_busy      = w_active;
    assign o_done      = (r_state == S_DONE);
    assign o_timeout   = r_timeout;
    assign o_in_count  = r_in_count;
    assign o_out_count = r_out_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = (i_frame_pixels == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_wd_fire) begin
                    w_next        = S_DONE;
                    w_set_timeout = 1'b1;
                end else if (w_in_last) begin
                    w_next = w_out_last ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wd_fire) begin
                    w_next        = S_DONE;
                    w_set_timeout = 1'b1;
                end else if (w_out_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_total     <= '0;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_wd        <= '0;
            r_timeout   <= 1'b0;
        end else if (w_accept) begin
            r_total     <= i_frame_pixels;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_wd        <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_in_count  <= w_in_next;
            r_out_count <= w_out_next;
            if (w_active) begin
                if (w_in_xfer || w_out_xfer) r_wd <= '0;
                else if (!w_wd_fire)         r_wd <= r_wd + 1'b1;
            end
            if (w_set_timeout) r_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench: behavioural source/datapath/sink FIFOs around frame_sequencer.
module tb_frame_sequencer;
    localparam int CW = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] frame_pixels = '0;
    logic          busy, done, timeout;
    logic [CW-1:0] in_count, out_count;

    frame_sequencer_if #(.DIN_W(24), .DOUT_W(8)) bus ();

    frame_sequencer #(
        .FIFO_DWIDTH_IN(24), .FIFO_DWIDTH_OUT(8), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start), .i_frame_pixels(frame_pixels),
        .o_busy(busy), .o_done(done), .o_timeout(timeout),
        .o_in_count(in_count), .o_out_count(out_count), .bus(bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [23:0] src_q[$];
    logic [23:0] in_q[$];
    logic [7:0]  out_q[$];
    logic [7:0]  snk_q[$];
    logic [7:0]  exp_q[$];
    int dp_limit = 1000;
    int dp_cnt = 0;
    int full_cycles = 0;
    bit tog_snk = 0;
    int viol = 0;
    int rd_seen = 0;
    int wr_seen = 0;

    function automatic logic [7:0] gray(input logic [23:0] p);
        int s;
        s = 77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0];
        return 8'(s >> 8);
    endfunction

    task automatic upd();
        bus.src_empty      = (src_q.size() == 0);
        bus.src_dout       = (src_q.size() != 0) ? src_q[0] : 24'h0;
        bus.fifo_out_empty = (out_q.size() == 0);
        bus.fifo_out_dout  = (out_q.size() != 0) ? out_q[0] : 8'h0;
    endtask

    // Enables are captured mid-cycle and applied just after the edge they acted on.
    logic c_src_rd, c_in_wr, c_out_rd, c_snk_wr;
    logic [23:0] c_in_din;
    logic [7:0]  c_snk_din;
    always @(negedge clock) begin
        c_src_rd  = bus.src_rd_en;
        c_in_wr   = bus.fifo_in_wr_en;
        c_in_din  = bus.fifo_in_din;
        c_out_rd  = bus.fifo_out_rd_en;
        c_snk_wr  = bus.snk_wr_en;
        c_snk_din = bus.snk_din;
        if (bus.fifo_in_full && bus.fifo_in_wr_en) viol++;
        if (bus.snk_full && bus.snk_wr_en) viol++;
        if (bus.src_rd_en) rd_seen++;
        if (bus.snk_wr_en) wr_seen++;
    end

    always @(posedge clock) begin
        logic [23:0] p;
        #1;
        if (reset) begin
            if (c_out_rd && out_q.size() != 0) void'(out_q.pop_front());
            if (dp_cnt < dp_limit && in_q.size() != 0) begin
                p = in_q.pop_front();
                out_q.push_back(gray(p));
                dp_cnt++;
            end
            if (c_src_rd && src_q.size() != 0) void'(src_q.pop_front());
            if (c_in_wr) in_q.push_back(c_in_din);
            if (c_snk_wr) snk_q.push_back(c_snk_din);
            upd();
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
        if (full_cycles > 0) begin bus.fifo_in_full = 1'b1; full_cycles--; end
        else bus.fifo_in_full = 1'b0;
        if (tog_snk) bus.snk_full = ~bus.snk_full;
    endtask

    task automatic flush();
        src_q.delete(); in_q.delete(); out_q.delete(); snk_q.delete(); exp_q.delete();
        dp_cnt = 0; dp_limit = 1000; viol = 0; rd_seen = 0; wr_seen = 0;
        upd();
    endtask

    // Equal R/G/B components make the luma exactly the component value.
    task automatic preload(input int n, input int seed);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = 8'(seed + 7 * i);
            src_q.push_back({v, v, v});
            exp_q.push_back(v);
        end
        upd();
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        frame_pixels = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcnt, output int idle,
                             output int max_run, output bit tout, output bit busy_fell);
        bit pb;
        int run;
        dcnt = 0; idle = 0; max_run = 0; run = 0; tout = 1; busy_fell = 1; pb = busy;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                dcnt++;
                if (pb !== 1'b1 || busy !== 1'b0) busy_fell = 0;
            end else if (dcnt > 0) begin
                tout = 0;
                break;
            end
            if (bus.fifo_in_wr_en) begin run++; if (run > max_run) max_run = run; end
            else run = 0;
            if (busy && !bus.fifo_in_wr_en && !bus.fifo_out_rd_en) idle++;
            pb = busy;
            tick();
        end
    endtask

    function automatic int order_errs();
        int m = 0;
        for (int i = 0; i < exp_q.size() && i < snk_q.size(); i++)
            if (snk_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        int guard;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (in_count !== 0) begin errors++; $display("FAIL rst_in_count: got %0d want 0", in_count); end
        tick(); reset = 1'b1; tick();
        flush(); preload(16, 3);
        do_start(16);
        guard = 0;
        while (in_count != 5 && guard < 50) begin tick(); guard++; end
        checks++; if (in_count !== 5) begin errors++; $display("FAIL rst_reach5: got %0d want 5", in_count); end
        reset = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b want 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_async_timeout: got %b want 0", timeout); end
        checks++; if (bus.fifo_in_wr_en !== 1'b0) begin errors++; $display("FAIL rst_async_inwr: got %b want 0", bus.fifo_in_wr_en); end
        checks++; if (bus.snk_wr_en !== 1'b0) begin errors++; $display("FAIL rst_async_snkwr: got %b want 0", bus.snk_wr_en); end
        tick(); tick();
        reset = 1'b1;
        flush();
        tick();
        checks++; if (in_count !== 0) begin errors++; $display("FAIL rst_in_count_after: got %0d want 0", in_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int dc, idl, mr; bit to, bf;
        flush(); preload(16, 5);
        do_start(16);
        wait_done(100, dc, idl, mr, to, bf);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_finish: got timeout-of-wait %b want 0", to); end
        checks++; if (mr !== 16) begin errors++; $display("FAIL basic_wr_run: got %0d want 16", mr); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_len: got %0d want 1", dc); end
        checks++; if (bf !== 1'b1) begin errors++; $display("FAIL basic_busy_fall: got %b want 1", bf); end
        checks++; if (in_count !== 16) begin errors++; $display("FAIL basic_in_count: got %0d want 16", in_count); end
        checks++; if (out_count !== 16) begin errors++; $display("FAIL basic_out_count: got %0d want 16", out_count); end
        checks++; if (snk_q.size() !== 16) begin errors++; $display("FAIL basic_snk_size: got %0d want 16", snk_q.size()); end
        checks++; if (order_errs() !== 0) begin errors++; $display("FAIL basic_order: got %0d bad want 0", order_errs()); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_backpressure();
        int dc, idl, mr; bit to, bf;
        flush(); preload(8, 40);
        bus.fifo_in_full = 1'b1; full_cycles = 5;
        tog_snk = 1;
        do_start(8);
        checks++; if (in_count !== 0 || bus.fifo_in_wr_en !== 1'b0) begin errors++;
            $display("FAIL bp_held: got count %0d wr %b want 0 0", in_count, bus.fifo_in_wr_en); end
        wait_done(200, dc, idl, mr, to, bf);
        tog_snk = 0; bus.snk_full = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_finish: got %b want 0", to); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_full_violation: got %0d want 0", viol); end
        checks++; if (in_count !== 8) begin errors++; $display("FAIL bp_in_count: got %0d want 8", in_count); end
        checks++; if (out_count !== 8) begin errors++; $display("FAIL bp_out_count: got %0d want 8", out_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", timeout); end
        checks++; if (snk_q.size() !== 8 || order_errs() !== 0) begin errors++;
            $display("FAIL bp_order: got size %0d bad %0d want 8 0", snk_q.size(), order_errs()); end
    endtask

    task automatic test_zero_length();
        flush(); preload(1, 9);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b want 0", done); end
        do_start(0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_len: got %b want 0", done); end
        tick(); tick();
        checks++; if (rd_seen !== 0 || wr_seen !== 0) begin errors++;
            $display("FAIL zero_no_xfer: got rd %0d wr %0d want 0 0", rd_seen, wr_seen); end
        checks++; if (in_count !== 0 || out_count !== 0) begin errors++;
            $display("FAIL zero_counts: got %0d %0d want 0 0", in_count, out_count); end
        checks++; if (src_q.size() !== 1) begin errors++; $display("FAIL zero_src_kept: got %0d want 1", src_q.size()); end
    endtask

    task automatic test_timeout();
        int dc, idl, mr; bit to, bf;
        flush(); preload(4, 60);
        dp_limit = 3;
        do_start(4);
        wait_done(100, dc, idl, mr, to, bf);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL to_finish: got %b want 0", to); end
        checks++; if (idl !== 8) begin errors++; $display("FAIL to_idle_cycles: got %0d want 8", idl); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL to_done_len: got %0d want 1", dc); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout); end
        checks++; if (out_count !== 3) begin errors++; $display("FAIL to_out_count: got %0d want 3", out_count); end
        checks++; if (in_count !== 4) begin errors++; $display("FAIL to_in_count: got %0d want 4", in_count); end
        checks++; if (in_q.size() !== 1) begin errors++; $display("FAIL to_inflight_kept: got %0d want 1", in_q.size()); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout); end
        flush();
        do_start(0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_cleared: got %b want 0", timeout); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int dc, idl, mr; bit to, bf;
        flush(); preload(16, 100);
        do_start(16);
        tick(); tick(); tick();
        start = 1'b1; frame_pixels = CW'(99);
        tick();
        start = 1'b0;
        wait_done(100, dc, idl, mr, to, bf);
        checks++; if (to !== 1'b0 || dc !== 1) begin errors++; $display("FAIL swb_finish: got wait %b done %0d want 0 1", to, dc); end
        checks++; if (in_count !== 16) begin errors++; $display("FAIL swb_in_count: got %0d want 16", in_count); end
        checks++; if (out_count !== 16) begin errors++; $display("FAIL swb_out_count: got %0d want 16", out_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_idle: got %b want 0", busy); end
        flush(); preload(2, 200);
        do_start(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_next_accept: got %b want 1", busy); end
        wait_done(50, dc, idl, mr, to, bf);
        checks++; if (in_count !== 2 || out_count !== 2) begin errors++;
            $display("FAIL swb_next_counts: got %0d %0d want 2 2", in_count, out_count); end
        checks++; if (snk_q.size() !== 2 || order_errs() !== 0) begin errors++;
            $display("FAIL swb_next_order: got size %0d bad %0d want 2 0", snk_q.size(), order_errs()); end
    endtask

    initial begin
        bus.fifo_in_full = 1'b0;
        bus.snk_full = 1'b0;
        flush();
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_length();
        test_timeout();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sequences one frame at a time through the grayscale datapath (input fifo -> dut -> output fifo).
- Pulls frame pixels from a source FIFO and pushes them into the datapath input fifo.
- Drains the datapath output fifo into a sink FIFO and counts both sides.
- Signals completion, or a watchdog timeout when the pipeline stalls.

Parameters:
FIFO_DWIDTH_IN, 24, pixel width on the source side and the datapath input fifo side.
FIFO_DWIDTH_OUT, 8, pixel width on the datapath output fifo side and the sink side.
CNT_WIDTH, 20, width of the frame length and of both pixel counters.
TIMEOUT_CYCLES, 1024, consecutive cycles with no transfer that trigger a timeout; minimum value is 1.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  single-cycle frame start request.
frame_pixels  in  CNT_WIDTH  pixel count of the frame; sampled when start is accepted.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle completion pulse.
timeout  out  1  sticky watchdog flag; cleared when the next start is accepted.
in_count  out  CNT_WIDTH  pixels written to the datapath this frame.
out_count  out  CNT_WIDTH  pixels delivered to the sink this frame.
src_empty  in  1  source FIFO empty; src_dout is valid when this is 0 (first-word-fall-through).
src_rd_en  out  1  source FIFO read.
src_dout  in  FIFO_DWIDTH_IN  source pixel.
fifo_in_wr_en  out  1  datapath input fifo write.
fifo_in_din  out  FIFO_DWIDTH_IN  datapath input pixel; equal to src_dout.
fifo_in_full  in  1  datapath input fifo full.
fifo_out_empty  in  1  datapath output fifo empty; fifo_out_dout is valid when this is 0.
fifo_out_rd_en  out  1  datapath output fifo read.
fifo_out_dout  in  FIFO_DWIDTH_OUT  datapath output pixel.
snk_wr_en  out  1  sink FIFO write.
snk_din  out  FIFO_DWIDTH_OUT  sink pixel; equal to fifo_out_dout.
snk_full  in  1  sink FIFO full.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, timeout, in_count, out_count, total and watchdog all 0.
- Reset effect on enables: all enables are 0 immediately, because they decode from state.
- States: IDLE, RUN, DRAIN, DONE. State register is binary-encoded.
- IDLE:
  - start=1 latches total=frame_pixels and clears in_count, out_count, watchdog and timeout.
  - Next state is RUN, or DONE if frame_pixels==0.
  - start is ignored in all other states.
- Input transfer (combinational, zero latency):
  - in_xfer = (state==RUN) & (in_count!=total) & !src_empty & !fifo_in_full.
  - src_rd_en = fifo_in_wr_en = in_xfer.
  - in_count increments on each in_xfer edge.
- Output transfer (combinational, zero latency):
  - out_xfer = (state==RUN|DRAIN) & (out_count!=total) & !fifo_out_empty & !snk_full.
  - fifo_out_rd_en = snk_wr_en = out_xfer.
  - out_count increments on each out_xfer edge.
- Simultaneous transfers: in_xfer and out_xfer may occur in the same cycle; the counters are independent.
- RUN -> DRAIN when in_count reaches total, counting the transfer of the current cycle.
- RUN -> DONE directly if out_count also reaches total in that same cycle.
- DRAIN -> DONE when out_count reaches total, counting the transfer of the current cycle.
- Watchdog (RUN/DRAIN):
  - Increments every cycle with neither in_xfer nor out_xfer; clears to 0 on any transfer.
  - When it reaches TIMEOUT_CYCLES-1 with no transfer: timeout<=1, next state DONE.
  - Counts are frozen at their current values.
- DONE: lasts exactly one cycle; done=1 (registered, decoded from state); next state IDLE.
- busy is decoded from state. Result: busy falls on the same edge that done rises.
- Counters never wrap: transfers are gated by count!=total.
- Pixel order is preserved; the block never drops or duplicates a pixel.
- In-flight pixels inside the datapath are never discarded by this block, including on timeout.

Test Plan:
1. Reset: assert reset=0 mid-RUN with 5 pixels sent -> busy, done, timeout, fifo_in_wr_en, snk_wr_en go 0 immediately, without waiting for a clock edge; in_count=0 after reset deasserts.
2. Basic frame: frame_pixels=16, source preloaded with 16 words, sink never full -> fifo_in_wr_en high for 16 consecutive cycles; in_count=16; out_count=16; done high for exactly 1 cycle; busy falls on the same edge; sink data matches the golden grayscale output in order.
3. Backpressure: frame_pixels=8, fifo_in_full held 1 for 5 cycles, snk_full toggling every cycle -> no wr_en while the respective full flag is 1; final in_count=8, out_count=8; sink order matches.
4. Zero-length frame: start with frame_pixels=0 -> done=1 on the second cycle after start; no src_rd_en or snk_wr_en ever asserted; counts stay 0.
5. Timeout: TIMEOUT_CYCLES=8, frame_pixels=4, datapath emits only 3 outputs -> timeout=1 after 8 transfer-free cycles; done pulses once; out_count=3; a new start clears timeout.
6. Start while busy: pulse start with frame_pixels=99 during RUN of a 16-pixel frame -> ignored; the frame completes with counts of 16; the next start in IDLE is accepted.
